fire_scheduler: RTL and testbench
=================================

Name: fire_scheduler

Overview:
- Sequences the 9-cell fire field for the firefighting game.
- Spawns fires at pseudo-random cells on a difficulty-scaled interval and ages each burning cell until it expires.
- Extinguishes a burning cell when its box switch toggles.
- Reports per-cycle hit/miss events to the game controller (score, life) and the fire bitmap to the display controller.
- Runs in the 25 MHz pixel-clock domain.

Parameters:
- N_CELL, 9, number of cells (fixed 9; width of box/fire_state).
- TICK_DIV, 2500000, clocks per game tick (10 Hz at 25 MHz).
- LIFETIME, 30, ticks a fire burns before it counts as a miss (1..31).
- SPAWN_INIT, 15, initial ticks between spawns (1..15).
- SPAWN_MIN, 4, floor of the spawn interval.
- HITS_PER_LEVEL, 4, cumulative hits per interval decrement.
- MAX_ACTIVE, 3, maximum simultaneous fires (1..9).
- LFSR_SEED, 8'hA5, LFSR reset value (non-zero).

Ports:
- clk  input  1  25 MHz clock.
- rst  input  1  asynchronous reset, active-low.
- enable  input  1  game running; low freezes the scheduler.
- clear  input  1  synchronous one-cycle pulse; empties the field and restores difficulty.
- box  input  9  raw box switches, asynchronous.
- fire_state  output  9  bit i = 1 when cell i is burning.
- hit_pulse  output  1  one-cycle pulse: at least one fire extinguished this cycle.
- hit_cnt  output  4  number of fires extinguished; valid with hit_pulse, else 0.
- miss_pulse  output  1  one-cycle pulse: at least one fire expired this cycle.
- miss_cnt  output  4  number of fires expired; valid with miss_pulse, else 0.
- active_cnt  output  4  popcount of fire_state.
- spawn_interval  output  4  current spawn interval in ticks.

Behaviour:
- Reset (rst=0, async):
  - fire_state, pulses, counts, tick/spawn counters, per-cell ages and hit accumulator = 0.
  - spawn_interval = SPAWN_INIT; LFSR = LFSR_SEED.
  - Sync/edge registers load 0.
- box path:
  - 2-flop synchronizer, then a previous-value register.
  - strike[i] = sync[i] XOR prev[i]; either switch direction counts.
  - prev updates every cycle regardless of enable, so there is no false strike on resume.
- LFSR:
  - 8-bit Fibonacci, taps 8,6,5,4.
  - Advances every clock, including while enable is low.
  - Never reaches zero.
- tick:
  - Counter 0..TICK_DIV-1, advancing only while enable=1.
  - tick asserts for one cycle at terminal count, then the counter wraps to 0.
- Per-cell state OFF/BURNING with a 5-bit age. Transitions, in priority order, evaluated on the registered state:
  1. BURNING & strike & enable -> OFF. Counts a hit, even if expiry would also occur this cycle.
  2. BURNING & tick & age==LIFETIME-1 -> OFF. Counts a miss.
  3. BURNING & tick -> age+1.
  4. OFF & strike -> no effect.
- Spawn:
  - spawn_cnt increments on tick.
  - On tick with spawn_cnt+1 >= spawn_interval and (active_cnt - cells leaving this cycle) < MAX_ACTIVE:
    - Target = LFSR[7:0] mod 9.
    - If the target is burning or leaving this cycle, probe upward (8 wraps to 0) to the first free cell.
    - Target -> BURNING, age 0; spawn_cnt -> 0.
  - If no slot is available, spawn_cnt saturates at spawn_interval and the spawn fires on the first tick with a free slot.
  - At most one spawn per tick.
- Difficulty:
  - 3-bit hit accumulator adds hit_cnt.
  - Each time it reaches or passes HITS_PER_LEVEL, subtract HITS_PER_LEVEL and decrement spawn_interval by 1, not below SPAWN_MIN.
- Outputs:
  - Registered; hit/miss pulses and counts appear the cycle after the causing event.
  - fire_state and active_cnt update in that same cycle.
- Simultaneous hit and miss in the same cycle: both pulses assert with their respective counts.
- enable=0: tick, ages and spawn_cnt hold; strikes ignored; fire_state holds; no pulses.
- clear=1: next cycle equals the reset state, except LFSR and box sync/prev, which continue. clear has priority over all events that cycle.
- Reset mid-operation: all outputs return to reset values immediately (asynchronous).

Test Plan (TICK_DIV=4, LIFETIME=5, SPAWN_INIT=3, SPAWN_MIN=2, HITS_PER_LEVEL=2, MAX_ACTIVE=3):
- Reset release, enable=1, no box activity -> first spawn on 3rd tick (cycle ~12); cell = seed mod 9 = 165 mod 9 = 3 if LFSR unadvanced (bench models LFSR); active_cnt=1.
- Leave cell unstruck -> 5 ticks after spawn fire_state bit clears; miss_pulse=1 for 1 cycle, miss_cnt=1.
- Toggle box[cell] while burning -> 3 cycles later (2 sync + 1 reg) bit clears, hit_pulse=1, hit_cnt=1; toggle of an OFF cell -> no pulse.
- Run until 3 fires burn -> no 4th spawn; spawn_cnt saturates; strike one -> new spawn on the next tick; probe picks the next free cell when LFSR hits a burning one.
- Strike 2 cells in one cycle -> hit_cnt=2, spawn_interval 3->2; further hits keep it at 2 (floor).
- enable=0 for 100 cycles with a fire burning -> no age change, no pulses; toggle box meanwhile -> no hit after re-enable. clear mid-run -> fire_state=0, spawn_interval=3. rst low mid-tick -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/fire_scheduler_if.sv
// ----------------------------------------------------------------------------
// fire_scheduler_if
//
// Purpose: groups the game-side signals of the fire scheduler into one
// bundle. The game controller (or a testbench) is the master: it drives the
// run/clear controls and the raw box switches, and it receives the fire
// bitmap and the per-cycle hit/miss events. The scheduler is the slave.
//
// Signals:
//   enable          master->slave  game running; low freezes the scheduler
//   clear           master->slave  one-cycle pulse, empties field, restores difficulty
//   box[N_CELL]     master->slave  raw box switches, asynchronous to clk
//   fire_state      slave->master  bit i = cell i burning
//   hit_pulse       slave->master  one-cycle pulse, >=1 fire extinguished
//   hit_cnt[4]      slave->master  fires extinguished (0 unless hit_pulse)
//   miss_pulse      slave->master  one-cycle pulse, >=1 fire expired
//   miss_cnt[4]     slave->master  fires expired (0 unless miss_pulse)
//   active_cnt[4]   slave->master  popcount of fire_state
//   spawn_interval  slave->master  current spawn interval in ticks
// ----------------------------------------------------------------------------
interface fire_scheduler_if #(
    parameter int N_CELL = 9
);
    logic              enable;
    logic              clear;
    logic [N_CELL-1:0] box;
    logic [N_CELL-1:0] fire_state;
    logic              hit_pulse;
    logic [3:0]        hit_cnt;
    logic              miss_pulse;
    logic [3:0]        miss_cnt;
    logic [3:0]        active_cnt;
    logic [3:0]        spawn_interval;

    modport master (
        output enable, clear, box,
        input  fire_state, hit_pulse, hit_cnt, miss_pulse, miss_cnt,
               active_cnt, spawn_interval
    );

    modport slave (
        input  enable, clear, box,
        output fire_state, hit_pulse, hit_cnt, miss_pulse, miss_cnt,
               active_cnt, spawn_interval
    );
endinterface

// File: rtl/fire_scheduler.sv
// ----------------------------------------------------------------------------
// fire_scheduler
//
// Purpose: sequences the 9-cell fire field of the firefighting game. Fires
// spawn at pseudo-random cells on a tick-based interval that shrinks as the
// player scores hits, each burning cell ages once per tick until it expires
// (a miss), and toggling a cell's box switch while it burns puts it out (a
// hit). All outputs are registered and appear the cycle after their cause.
//
// Ports:
//   clk   25 MHz pixel clock
//   rst   asynchronous reset, active low
//   bus   fire_scheduler_if.slave (enable/clear/box in; fire bitmap and
//         hit/miss/active/interval reporting out)
// ----------------------------------------------------------------------------
module fire_scheduler #(
    parameter int         N_CELL         = 9,
    parameter int         TICK_DIV       = 2500000,
    parameter int         LIFETIME       = 30,
    parameter int         SPAWN_INIT     = 15,
    parameter int         SPAWN_MIN      = 4,
    parameter int         HITS_PER_LEVEL = 4,
    parameter int         MAX_ACTIVE     = 3,
    parameter logic [7:0] LFSR_SEED      = 8'hA5
) (
    input  logic            clk,
    input  logic            rst,
    fire_scheduler_if.slave bus
);

    typedef enum logic {
        CELL_OFF     = 1'b0,
        CELL_BURNING = 1'b1
    } cell_state_e;

    localparam int                TICK_W        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST     = TICK_W'(TICK_DIV - 1);
    localparam logic [4:0]        AGE_LAST      = 5'(LIFETIME - 1);
    localparam logic [3:0]        INTERVAL_INIT = 4'(SPAWN_INIT);
    localparam logic [3:0]        INTERVAL_MIN  = 4'(SPAWN_MIN);
    localparam logic [4:0]        LEVEL_STEP    = 5'(HITS_PER_LEVEL);
    localparam logic [3:0]        ACTIVE_MAX    = 4'(MAX_ACTIVE);
    localparam logic [7:0]        CELL_MOD      = 8'(N_CELL);
    localparam logic [4:0]        CELL_LAST     = 5'(N_CELL - 1);

    function automatic logic [3:0] popcount(input logic [N_CELL-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < N_CELL; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // ------------------------------------------------------------------
    // Box synchronizer, edge detect and LFSR. These run every cycle
    // regardless of enable/clear so a switch flipped while the game is
    // frozen is absorbed into box_prev_q and never strikes on resume.
    // ------------------------------------------------------------------
    logic [N_CELL-1:0] box_meta_q;
    logic [N_CELL-1:0] box_sync_q;
    logic [N_CELL-1:0] box_prev_q;
    logic [N_CELL-1:0] strike;
    logic [7:0]        lfsr_q;
    logic [7:0]        lfsr_d;

    // Either switch direction counts as a strike.
    assign strike = box_sync_q ^ box_prev_q;

    // Fibonacci taps 8,6,5,4 (maximal length, so a non-zero seed never
    // reaches the all-zero lock-up state).
    assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            box_meta_q <= '0;
            box_sync_q <= '0;
            box_prev_q <= '0;
            lfsr_q     <= LFSR_SEED;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples the pre-edge value; blocking here would collapse
            // the synchronizer chain into a single flop.
            box_meta_q <= bus.box;
            box_sync_q <= box_meta_q;
            box_prev_q <= box_sync_q;
            lfsr_q     <= lfsr_d;
        end
    end

    // ------------------------------------------------------------------
    // Game tick: one-cycle strobe at the terminal count of a free-running
    // divider that only advances while the game is enabled.
    // ------------------------------------------------------------------
    logic [TICK_W-1:0] tick_cnt_q;
    logic [TICK_W-1:0] tick_cnt_d;
    logic              tick;

    always_comb begin
        // NOTE: every variable written in a combinational block gets a
        // default first, so no path leaves it unassigned and no latch is
        // inferred.
        tick       = bus.enable && (tick_cnt_q == TICK_LAST);
        tick_cnt_d = tick_cnt_q;
        if (bus.clear) begin
            tick_cnt_d = '0;
        end else if (bus.enable) begin
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
        end
    end

    // ------------------------------------------------------------------
    // Cell field, spawn and difficulty
    // ------------------------------------------------------------------
    cell_state_e       cell_q [N_CELL];
    cell_state_e       cell_d [N_CELL];
    logic [4:0]        age_q  [N_CELL];
    logic [4:0]        age_d  [N_CELL];
    logic [3:0]        spawn_cnt_q, spawn_cnt_d;
    logic [3:0]        interval_q,  interval_d;
    logic [2:0]        acc_q,       acc_d;
    logic              hit_pulse_q, hit_pulse_d;
    logic [3:0]        hit_cnt_q,   hit_cnt_d;
    logic              miss_pulse_q, miss_pulse_d;
    logic [3:0]        miss_cnt_q,  miss_cnt_d;
    logic [3:0]        active_q,    active_d;

    logic [N_CELL-1:0] fire_vec;
    logic [N_CELL-1:0] fire_next;
    logic [N_CELL-1:0] hit_vec;
    logic [N_CELL-1:0] miss_vec;
    logic [N_CELL-1:0] stay_vec;
    logic [3:0]        hit_n;
    logic [3:0]        miss_n;
    logic              spawn_due;
    logic              slot_free;
    logic              found;
    logic              do_spawn;
    logic [3:0]        probe_start;
    logic [4:0]        probe_sum;
    logic [3:0]        probe_idx;
    logic [3:0]        target;
    logic [4:0]        acc_work;

    always_comb begin
        fire_vec = '0;
        for (int i = 0; i < N_CELL; i++) begin
            fire_vec[i] = (cell_q[i] == CELL_BURNING);
        end
    end

    always_comb begin
        cell_d       = cell_q;
        age_d        = age_q;
        hit_vec      = '0;
        miss_vec     = '0;
        spawn_cnt_d  = spawn_cnt_q;
        found        = 1'b0;
        target       = '0;
        probe_sum    = '0;
        probe_idx    = '0;

        // Per-cell transitions. A strike wins over a simultaneous expiry.
        for (int i = 0; i < N_CELL; i++) begin
            if (cell_q[i] == CELL_BURNING) begin
                if (strike[i] && bus.enable) begin
                    cell_d[i]  = CELL_OFF;
                    age_d[i]   = '0;
                    hit_vec[i] = 1'b1;
                end else if (tick && (age_q[i] == AGE_LAST)) begin
                    cell_d[i]   = CELL_OFF;
                    age_d[i]    = '0;
                    miss_vec[i] = 1'b1;
                end else if (tick) begin
                    age_d[i] = age_q[i] + 5'd1;
                end
            end
        end

        hit_n    = popcount(hit_vec);
        miss_n   = popcount(miss_vec);
        stay_vec = fire_vec & ~(hit_vec | miss_vec);

        // Slot accounting uses the cells that remain burning after this
        // cycle's hits and misses, but the probe treats a leaving cell as
        // occupied so a fire never respawns in the cell it just left.
        spawn_due   = tick && (({1'b0, spawn_cnt_q} + 5'd1) >= {1'b0, interval_q});
        slot_free   = popcount(stay_vec) < ACTIVE_MAX;
        probe_start = 4'(lfsr_q % CELL_MOD);

        for (int k = 0; k < N_CELL; k++) begin
            probe_sum = {1'b0, probe_start} + 5'(k);
            probe_idx = (probe_sum > CELL_LAST) ? 4'(probe_sum - 5'(N_CELL)) : probe_sum[3:0];
            if (!found && !fire_vec[probe_idx]) begin
                found  = 1'b1;
                target = probe_idx;
            end
        end

        do_spawn = spawn_due && slot_free && found;

        // spawn_cnt saturates at the interval so a blocked spawn fires on
        // the first tick that finds a free slot.
        if (tick) begin
            if (do_spawn) begin
                cell_d[target] = CELL_BURNING;
                age_d[target]  = '0;
                spawn_cnt_d    = '0;
            end else if (spawn_cnt_q >= interval_q) begin
                spawn_cnt_d = interval_q;
            end else begin
                spawn_cnt_d = spawn_cnt_q + 4'd1;
            end
        end

        // Difficulty: every HITS_PER_LEVEL cumulative hits shorten the
        // spawn interval by one tick, never below SPAWN_MIN. Several levels
        // can be crossed in one cycle when many cells are struck together.
        acc_work   = {2'b00, acc_q} + {1'b0, hit_n};
        interval_d = interval_q;
        for (int k = 0; k < 16; k++) begin
            if (acc_work >= LEVEL_STEP) begin
                acc_work = acc_work - LEVEL_STEP;
                if (interval_d > INTERVAL_MIN) begin
                    interval_d = interval_d - 4'd1;
                end
            end
        end
        acc_d = acc_work[2:0];

        hit_pulse_d  = |hit_vec;
        hit_cnt_d    = hit_n;
        miss_pulse_d = |miss_vec;
        miss_cnt_d   = miss_n;

        // clear overrides every event evaluated above.
        if (bus.clear) begin
            for (int i = 0; i < N_CELL; i++) begin
                cell_d[i] = CELL_OFF;
                age_d[i]  = '0;
            end
            spawn_cnt_d  = '0;
            interval_d   = INTERVAL_INIT;
            acc_d        = '0;
            hit_pulse_d  = 1'b0;
            hit_cnt_d    = '0;
            miss_pulse_d = 1'b0;
            miss_cnt_d   = '0;
        end

        fire_next = '0;
        for (int i = 0; i < N_CELL; i++) begin
            fire_next[i] = (cell_d[i] == CELL_BURNING);
        end
        active_d = popcount(fire_next);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the per-cell age array is ordinary flops, not a RAM, so
            // it takes the reset like any other state and no stale age can
            // leak into a freshly spawned fire.
            for (int i = 0; i < N_CELL; i++) begin
                cell_q[i] <= CELL_OFF;
                age_q[i]  <= '0;
            end
            tick_cnt_q   <= '0;
            spawn_cnt_q  <= '0;
            interval_q   <= INTERVAL_INIT;
            acc_q        <= '0;
            hit_pulse_q  <= 1'b0;
            hit_cnt_q    <= '0;
            miss_pulse_q <= 1'b0;
            miss_cnt_q   <= '0;
            active_q     <= '0;
        end else begin
            cell_q       <= cell_d;
            age_q        <= age_d;
            tick_cnt_q   <= tick_cnt_d;
            spawn_cnt_q  <= spawn_cnt_d;
            interval_q   <= interval_d;
            acc_q        <= acc_d;
            hit_pulse_q  <= hit_pulse_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_pulse_q <= miss_pulse_d;
            miss_cnt_q   <= miss_cnt_d;
            active_q     <= active_d;
        end
    end

    assign bus.fire_state     = fire_vec;
    assign bus.hit_pulse      = hit_pulse_q;
    assign bus.hit_cnt        = hit_cnt_q;
    assign bus.miss_pulse     = miss_pulse_q;
    assign bus.miss_cnt       = miss_cnt_q;
    assign bus.active_cnt     = active_q;
    assign bus.spawn_interval = interval_q;

endmodule

// File: tb/tb_fire_scheduler.sv
// ----------------------------------------------------------------------------
// tb_fire_scheduler
//
// Self-checking bench for fire_scheduler with short game timing. A
// behavioural reference model is stepped with the inputs the DUT will sample
// at the next rising edge; its predicted outputs are queued and compared
// with the DUT outputs 1 ns after that edge. Directed checks cover reset
// values, the spawn-interval floor, clear and an asynchronous mid-cycle
// reset.
// ----------------------------------------------------------------------------
module tb_fire_scheduler;

    localparam int         N_CELL         = 9;
    localparam int         TICK_DIV       = 4;
    localparam int         LIFETIME       = 5;
    localparam int         SPAWN_INIT     = 3;
    localparam int         SPAWN_MIN      = 2;
    localparam int         HITS_PER_LEVEL = 2;
    localparam int         MAX_ACTIVE     = 3;
    localparam logic [7:0] LFSR_SEED      = 8'hA5;

    logic clk;
    logic rst;

    fire_scheduler_if #(.N_CELL(N_CELL)) bus ();

    fire_scheduler #(
        .N_CELL         (N_CELL),
        .TICK_DIV       (TICK_DIV),
        .LIFETIME       (LIFETIME),
        .SPAWN_INIT     (SPAWN_INIT),
        .SPAWN_MIN      (SPAWN_MIN),
        .HITS_PER_LEVEL (HITS_PER_LEVEL),
        .MAX_ACTIVE     (MAX_ACTIVE),
        .LFSR_SEED      (LFSR_SEED)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    bit [8:0]    m_meta, m_sync, m_prev;
    bit [7:0]    m_lfsr;
    int          m_tick;
    bit [8:0]    m_burn;
    int          m_age [9];
    int          m_scnt, m_intv, m_acc;
    logic [26:0] m_out;
    logic [26:0] exp_q [$];

    task automatic model_reset();
        m_meta = '0; m_sync = '0; m_prev = '0;
        m_lfsr = LFSR_SEED;
        m_tick = 0; m_burn = '0;
        for (int i = 0; i < 9; i++) m_age[i] = 0;
        m_scnt = 0; m_intv = SPAWN_INIT; m_acc = 0;
        m_out  = {9'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 4'(SPAWN_INIT)};
    endtask

    task automatic model_step(input bit en, input bit clr, input logic [8:0] bx);
        bit [8:0] strike, nb;
        int       nage [9];
        int       hits, misses, start, tgt;
        bit       tk, found;
        strike = m_sync ^ m_prev;
        tk     = en && (m_tick == TICK_DIV - 1);
        nb     = m_burn;
        nage   = m_age;
        hits   = 0;
        misses = 0;
        for (int i = 0; i < 9; i++) begin
            if (m_burn[i]) begin
                if (en && strike[i])                         begin nb[i] = 0; hits++;   end
                else if (tk && m_age[i] == LIFETIME - 1)     begin nb[i] = 0; misses++; end
                else if (tk)                                 nage[i] = m_age[i] + 1;
            end
        end
        if (tk) begin
            found = 0;
            if ((m_scnt + 1 >= m_intv) && ($countones(nb) < MAX_ACTIVE)) begin
                start = m_lfsr % 9;
                for (int k = 0; k < 9; k++) begin
                    tgt = (start + k) % 9;
                    if (!found && !m_burn[tgt]) begin
                        found = 1; nb[tgt] = 1; nage[tgt] = 0;
                    end
                end
            end
            m_scnt = found ? 0 : ((m_scnt + 1 > m_intv) ? m_intv : m_scnt + 1);
        end
        if (en) m_tick = (m_tick == TICK_DIV - 1) ? 0 : m_tick + 1;
        m_acc += hits;
        while (m_acc >= HITS_PER_LEVEL) begin
            m_acc -= HITS_PER_LEVEL;
            if (m_intv > SPAWN_MIN) m_intv--;
        end
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
        m_prev = m_sync;
        m_sync = m_meta;
        m_meta = bx;
        if (clr) begin
            nb = '0;
            for (int i = 0; i < 9; i++) nage[i] = 0;
            m_tick = 0; m_scnt = 0; m_acc = 0; m_intv = SPAWN_INIT;
            hits = 0; misses = 0;
        end
        m_burn = nb;
        m_age  = nage;
        m_out  = {nb, hits > 0, 4'(hits), misses > 0, 4'(misses), 4'($countones(nb)), 4'(m_intv)};
    endtask

    function automatic logic [26:0] dut_out();
        return {bus.fire_state, bus.hit_pulse, bus.hit_cnt, bus.miss_pulse,
                bus.miss_cnt, bus.active_cnt, bus.spawn_interval};
    endfunction

    // One clock: predict, push, clock the DUT, pop and compare.
    task automatic step();
        logic [26:0] e;
        model_step(bus.enable, bus.clear, bus.box);
        exp_q.push_back(m_out);
        @(posedge clk);
        #1;
        cyc++;
        e = exp_q.pop_front();
        check($sformatf("outputs_cyc%0d", cyc), 32'(dut_out()), 32'(e));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Step until the model holds at least 'need' fires no older than
    // 'max_age', within 'budget' cycles.
    task automatic wait_fires(input string tag, input int need, input int max_age, input int budget);
        int got;
        bit ok;
        ok = 0;
        for (int c = 0; c < budget && !ok; c++) begin
            step();
            got = 0;
            for (int i = 0; i < 9; i++) if (m_burn[i] && m_age[i] <= max_age) got++;
            if (got >= need) ok = 1;
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic toggle_fresh(input int max_age, input int count);
        int n;
        n = 0;
        for (int i = 0; i < 9; i++) begin
            if (m_burn[i] && m_age[i] <= max_age && n < count) begin
                bus.box[i] = ~bus.box[i];
                n++;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        int r;
        rst        = 1'b0;
        bus.enable = 1'b0;
        bus.clear  = 1'b0;
        bus.box    = '0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("reset_fire_state", 32'(bus.fire_state), 32'd0);
        check("reset_hit",        32'({bus.hit_pulse, bus.hit_cnt}), 32'd0);
        check("reset_miss",       32'({bus.miss_pulse, bus.miss_cnt}), 32'd0);
        check("reset_active",     32'(bus.active_cnt), 32'd0);
        check("reset_interval",   32'(bus.spawn_interval), 32'(SPAWN_INIT));

        // First spawn on the 3rd tick, then let it burn out unstruck.
        rst        = 1'b1;
        bus.enable = 1'b1;
        run(40);

        // Strike a young fire: hit three cycles later.
        wait_fires("wait_single_fire", 1, 2, 80);
        toggle_fresh(2, 1);
        run(5);

        // Toggle a cell that is not burning: no hit expected.
        for (int i = 0; i < 9; i++) begin
            if (!m_burn[i]) begin
                bus.box[i] = ~bus.box[i];
                break;
            end
        end
        run(5);

        // Two strikes in one cycle: hit_cnt 2 and the interval drops to the floor.
        wait_fires("wait_two_fires", 2, 3, 200);
        toggle_fresh(3, 2);
        run(5);
        check("interval_floor", 32'(bus.spawn_interval), 32'(SPAWN_MIN));

        // Mixed random play: strikes biased toward burning cells, enable dropouts.
        for (int c = 0; c < 300; c++) begin
            r = $urandom_range(0, 8);
            if (($urandom_range(0, 2) == 0) && (m_burn[r] || $urandom_range(0, 7) == 0))
                bus.box[r] = ~bus.box[r];
            if ($urandom_range(0, 19) == 0) bus.enable = ~bus.enable;
            step();
        end
        bus.enable = 1'b1;
        run(4);
        check("interval_floor_hold", 32'(bus.spawn_interval), 32'(SPAWN_MIN));

        // Freeze with a fire burning; a toggle while frozen must not hit later.
        wait_fires("wait_fire_freeze", 1, LIFETIME - 1, 80);
        bus.enable = 1'b0;
        run(50);
        toggle_fresh(LIFETIME - 1, 1);
        run(50);
        bus.enable = 1'b1;
        run(30);

        // clear mid-run.
        run(7);
        bus.clear = 1'b1;
        step();
        bus.clear = 1'b0;
        check("clear_fire_state", 32'(bus.fire_state), 32'd0);
        check("clear_interval",   32'(bus.spawn_interval), 32'(SPAWN_INIT));
        run(30);

        // Asynchronous reset between clock edges.
        #3;
        rst = 1'b0;
        #1;
        model_reset();
        check("async_reset_outputs", 32'(dut_out()), 32'(m_out));
        check("async_reset_active",  32'(bus.active_cnt), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b1;
        run(40);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
